// File: rtl/vga_fb_reader.sv
// vga_fb_reader: raster timing generator and sequential 8-bit frame-buffer reader.
// Ports: PIXELCLK/RSTN clock and sync active-low reset; i_w_en writer-owns-buffer;
// o_rd_en/o_rd_addr/i_rd_data buffer read port; o_data/o_de/VGA_HS/VGA_VS/
// o_frame_start pixel, enable, active-low syncs and frame pulse, all aligned.
module vga_fb_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19,
  parameter int RD_LAT   = 1
) (
  input  logic              PIXELCLK,
  input  logic              RSTN,
  input  logic              i_w_en,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [7:0]        i_rd_data,
  output logic [7:0]        o_data,
  output logic              o_de,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int HS_B = H_ACTIVE + H_FP;
  localparam int HS_E = HS_B + H_SYNC;
  localparam int VS_B = V_ACTIVE + V_FP;
  localparam int VS_E = VS_B + V_SYNC;

  // Pipeline bit layout: {frame_start, vs_n, hs_n, de, rd_en}
  localparam logic [4:0] PIPE_RST = 5'b01100;

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_cur;
  logic              blank_q, blank_d, blank_cur;
  logic              origin, h_last, v_last, visible, hs_n, vs_n;
  logic [4:0]        stg0;
  logic [4:0]        pipe_q [RD_LAT+1];
  logic [ADDR_W-1:0] rd_addr_q;
  logic [7:0]        data_q;
  logic              de_q, hs_q, vs_q, fs_q;

  always_comb begin
    origin  = (h_q == '0) && (v_q == '0);
    h_last  = (h_q == HW'(H_TOTAL - 1));
    v_last  = (v_q == VW'(V_TOTAL - 1));
    h_d     = h_last ? '0 : h_q + 1'b1;
    v_d     = v_q;
    if (h_last) v_d = v_last ? '0 : v_q + 1'b1;
    // blank decision is taken on the first pixel itself, so it
    // already governs the read of pixel (0,0)
    blank_cur = origin ? i_w_en : blank_q;
    blank_d   = blank_cur;
    visible   = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    addr_cur  = origin ? '0 : addr_q;
    addr_d    = visible ? addr_cur + 1'b1 : addr_cur;
    hs_n      = !((h_q >= HW'(HS_B)) && (h_q < HW'(HS_E)));
    vs_n      = !((v_q >= VW'(VS_B)) && (v_q < VW'(VS_E)));
    stg0      = {origin, vs_n, hs_n, visible, visible & ~blank_cur};
  end

  always_ff @(posedge PIXELCLK) begin
    if (!RSTN) begin
      h_q       <= '0;
      v_q       <= '0;
      addr_q    <= '0;
      blank_q   <= 1'b0;
      rd_addr_q <= '0;
      for (int i = 0; i <= RD_LAT; i++) pipe_q[i] <= PIPE_RST;
      data_q    <= 8'h00;
      de_q      <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      fs_q      <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      addr_q    <= addr_d;
      blank_q   <= blank_d;
      rd_addr_q <= addr_cur;
      pipe_q[0] <= stg0;
      for (int i = 1; i <= RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      // pipe_q[RD_LAT] lines up with the returning read data
      data_q    <= pipe_q[RD_LAT][0] ? i_rd_data : 8'h00;
      de_q      <= pipe_q[RD_LAT][1];
      hs_q      <= pipe_q[RD_LAT][2];
      vs_q      <= pipe_q[RD_LAT][3];
      fs_q      <= pipe_q[RD_LAT][4];
    end
  end

  assign o_rd_en       = pipe_q[0][0];
  assign o_rd_addr     = rd_addr_q;
  assign o_data        = data_q;
  assign o_de          = de_q;
  assign VGA_HS        = hs_q;
  assign VGA_VS        = vs_q;
  assign o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: directed bench on a reduced 15x10 raster,
// one instance with RD_LAT=1 and one with RD_LAT=3.
module tb_vga_fb_reader;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HSY = 3;
  localparam int HB = 2;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VSY = 2;
  localparam int VB = 1;
  localparam int AW = 6;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, w_en;
  logic rd1, de1, hs1, vs1, fs1;
  logic rd3, de3, hs3, vs3, fs3;
  logic [AW-1:0] ad1, ad3;
  logic [7:0] rdat1, dat1, rdat3, dat3;
  logic [7:0] m3_q [3];

  int total = 0;
  int bad = 0;
  int blank_pat [8];

  vga_fb_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .ADDR_W(AW), .RD_LAT(1)
  ) dut1 (
    .PIXELCLK(clk), .RSTN(rstn), .i_w_en(w_en),
    .o_rd_en(rd1), .o_rd_addr(ad1), .i_rd_data(rdat1),
    .o_data(dat1), .o_de(de1), .VGA_HS(hs1), .VGA_VS(vs1),
    .o_frame_start(fs1)
  );

  vga_fb_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .ADDR_W(AW), .RD_LAT(3)
  ) dut3 (
    .PIXELCLK(clk), .RSTN(rstn), .i_w_en(w_en),
    .o_rd_en(rd3), .o_rd_addr(ad3), .i_rd_data(rdat3),
    .o_data(dat3), .o_de(de3), .VGA_HS(hs3), .VGA_VS(vs3),
    .o_frame_start(fs3)
  );

  function automatic logic [7:0] memf(logic [AW-1:0] a);
    return {2'b00, a} ^ 8'h5A;
  endfunction

  // memory returns EE when not strobed, so ungated data shows up
  always_ff @(posedge clk) begin
    rdat1   <= rd1 ? memf(ad1) : 8'hEE;
    m3_q[0] <= rd3 ? memf(ad3) : 8'hEE;
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign rdat3 = m3_q[2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(string nm, logic rd, logic [AW-1:0] ad,
                         logic [7:0] dat, logic de, logic hs,
                         logic vs, logic fs);
    chk({nm, ".rst_rd_en"}, 32'(rd), 0);
    chk({nm, ".rst_rd_addr"}, 32'(ad), 0);
    chk({nm, ".rst_data"}, 32'(dat), 0);
    chk({nm, ".rst_de"}, 32'(de), 0);
    chk({nm, ".rst_hs"}, 32'(hs), 1);
    chk({nm, ".rst_vs"}, 32'(vs), 1);
    chk({nm, ".rst_fs"}, 32'(fs), 0);
  endtask

  // c = cycles since reset release; stage0 shows pixel c,
  // stage1 pixel c-1, output pins pixel c-(2+lat)
  task automatic chk_dut(string nm, int lat, int c, logic rd,
                         logic [AW-1:0] ad, logic [7:0] dat,
                         logic de, logic hs, logic vs, logic fs);
    int t, h, v;
    logic vis, blk, hse, vse;
    t = c - 1;
    h = t % HT;
    v = (t / HT) % VT;
    vis = (h < HA) && (v < VA);
    blk = blank_pat[t / FT] != 0;
    chk({nm, ".rd_en"}, 32'(rd), 32'(vis && !blk));
    if (vis) chk({nm, ".rd_addr"}, 32'(ad), v * HA + h);
    t = c - lat - 2;
    if (t < 0) begin
      chk({nm, ".fill_data"}, 32'(dat), 0);
      chk({nm, ".fill_de"}, 32'(de), 0);
      chk({nm, ".fill_hs"}, 32'(hs), 1);
      chk({nm, ".fill_vs"}, 32'(vs), 1);
      chk({nm, ".fill_fs"}, 32'(fs), 0);
    end else begin
      h = t % HT;
      v = (t / HT) % VT;
      vis = (h < HA) && (v < VA);
      blk = blank_pat[t / FT] != 0;
      hse = !((h >= HA + HF) && (h < HA + HF + HSY));
      vse = !((v >= VA + VF) && (v < VA + VF + VSY));
      chk({nm, ".data"}, 32'(dat),
          (vis && !blk) ? 32'(memf(AW'(v * HA + h))) : 0);
      chk({nm, ".de"}, 32'(de), 32'(vis));
      chk({nm, ".hs"}, 32'(hs), 32'(hse));
      chk({nm, ".vs"}, 32'(vs), 32'(vse));
      chk({nm, ".fs"}, 32'(fs), 32'(h == 0 && v == 0));
    end
  endtask

  task automatic chk_both(int c);
    chk_dut("d1", 1, c, rd1, ad1, dat1, de1, hs1, vs1, fs1);
    chk_dut("d3", 3, c, rd3, ad3, dat3, de3, hs3, vs3, fs3);
  endtask

  task automatic chk_rst_both();
    chk_rst("d1", rd1, ad1, dat1, de1, hs1, vs1, fs1);
    chk_rst("d3", rd3, ad3, dat3, de3, hs3, vs3, fs3);
  endtask

  initial begin
    rstn = 1'b0;
    w_en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk_rst_both();
    end
    // frames: read, blank, read, blank, read, read
    blank_pat = '{0, 1, 0, 1, 0, 0, 0, 0};
    rstn = 1'b1;
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      chk_both(c);
      if (c == 45)  w_en = 1'b1;
      if (c == 195) w_en = 1'b0;
      if (c == 360) w_en = 1'b1;
      if (c == 480) w_en = 1'b0;
    end
    // one-cycle reset at h=5,v=3 of frame 5
    rstn = 1'b0;
    @(negedge clk);
    chk_rst_both();
    // writer owns the buffer on the very first sampled cycle
    blank_pat = '{1, 0, 0, 0, 0, 0, 0, 0};
    rstn = 1'b1;
    w_en = 1'b1;
    for (int c = 1; c <= 320; c++) begin
      @(negedge clk);
      chk_both(c);
      if (c == 10) w_en = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
